// File: rtl/phase_sequencer.sv
// phase_sequencer: multi-cycle instruction phase controller.
// Steps each instruction through FETCH -> DECODE -> (EXEC | MEM) -> WB.
// It can pause after every instruction (step mode), halt between
// instructions on request, and halt with an error if memory stalls too long.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start                 begin from IDLE / resume from PAUSE
//   step_mode             pause after each retired instruction
//   halt_req              request halt at the next instruction boundary
//   opcode                instruction opcode (decoding is done upstream)
//   ctl_*                 decoded controls: regWE, accWE, memWE, brnch, mem_sc
//   acc_nz                accumulator is non-zero
//   mem_ready             memory access completes this cycle
//   ir_we .. addr_sel     datapath strobes (combinational)
//   busy, halted, err     status flags
//   state                 registered state encoding
//   instr_cnt             retired-instruction counter (wraps)
module phase_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        step_mode,
  input  logic        halt_req,
  input  logic [2:0]  opcode,
  input  logic        ctl_regWE,
  input  logic        ctl_accWE,
  input  logic        ctl_memWE,
  input  logic        ctl_brnch,
  input  logic        ctl_mem_sc,
  input  logic        acc_nz,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        acc_we,
  output logic        reg_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [2:0]  state,
  output logic [15:0] instr_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    PAUSE  = 3'd6,
    HALT   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        halt_pend_q, halt_pend_d;
  logic        err_q, err_d;
  logic [15:0] instr_cnt_q, instr_cnt_d;

  logic mem_phase;
  logic starved;
  logic timeout;
  logic halt_now;

  // Opcode is already decoded into ctl_* upstream; kept on the port list.
  logic unused_opcode;
  assign unused_opcode = ^opcode;

  assign mem_phase = (state_q == FETCH) || (state_q == MEM);
  assign starved   = mem_phase && !mem_ready;
  // 16th consecutive stalled cycle in the same phase.
  assign timeout   = starved && (wait_q == 4'hF);
  // A request arriving in the boundary cycle itself is honoured immediately.
  assign halt_now  = halt_pend_q || halt_req;

  // State and status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      halt_pend_q <= 1'b0;
      err_q       <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      halt_pend_q <= halt_pend_d;
      err_q       <= err_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (halt_req)   state_d = HALT;
        else if (start) state_d = FETCH;
      end
      FETCH: begin
        if (mem_ready)    state_d = DECODE;
        else if (timeout) state_d = HALT;
      end
      DECODE: state_d = ctl_mem_sc ? MEM : EXEC;
      EXEC:   state_d = WB;
      MEM: begin
        if (mem_ready)    state_d = WB;
        else if (timeout) state_d = HALT;
      end
      WB: begin
        if (halt_now)       state_d = HALT;
        else if (step_mode) state_d = PAUSE;
        else                state_d = FETCH;
      end
      PAUSE: begin
        if (halt_now)   state_d = HALT;
        else if (start) state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Wait timer, sticky flags and retire counter
  always_comb begin
    wait_d      = '0;
    if ((state_d == state_q) && starved) wait_d = wait_q + 4'd1;
    halt_pend_d = halt_pend_q || (halt_req && (state_q != IDLE));
    err_d       = err_q || timeout;
    instr_cnt_d = (state_q == WB) ? instr_cnt_q + 16'd1 : instr_cnt_q;
  end

  // Strobes: combinational from registered state, forced low during reset
  always_comb begin
    ir_we    = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    acc_we   = 1'b0;
    reg_we   = 1'b0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    busy     = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        FETCH: begin
          busy   = 1'b1;
          mem_re = 1'b1;
          ir_we  = mem_ready;
          pc_inc = mem_ready;
        end
        DECODE, EXEC: busy = 1'b1;
        MEM: begin
          busy     = 1'b1;
          addr_sel = 1'b1;
          mem_we   = ctl_memWE;
          mem_re   = !ctl_memWE;
        end
        WB: begin
          busy    = 1'b1;
          acc_we  = ctl_accWE;
          reg_we  = ctl_regWE;
          pc_load = ctl_brnch && acc_nz;
        end
        default: busy = 1'b0;
      endcase
    end
  end

  assign halted    = (state_q == HALT);
  assign err       = err_q;
  assign state     = state_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: a phase-level reference model advanced on
// each rising edge, compared against every output on each falling edge,
// plus directed scenarios with hand-computed literal expectations.
module tb_phase_sequencer;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3;
  localparam int S_MEM = 4, S_WB = 5, S_PAUSE = 6, S_HALT = 7;

  logic clk = 1'b0;
  logic rst_n, start, step_mode, halt_req;
  logic [2:0] opcode;
  logic ctl_regWE, ctl_accWE, ctl_memWE, ctl_brnch, ctl_mem_sc, acc_nz, mem_ready;
  logic ir_we, pc_inc, pc_load, acc_we, reg_we, mem_re, mem_we, addr_sel;
  logic busy, halted, err;
  logic [2:0] state;
  logic [15:0] instr_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  int          m_st;
  logic [15:0] m_cnt;
  int          m_wait;
  bit          m_hp, m_err;

  always #5 clk = ~clk;

  phase_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode),
    .halt_req(halt_req), .opcode(opcode),
    .ctl_regWE(ctl_regWE), .ctl_accWE(ctl_accWE), .ctl_memWE(ctl_memWE),
    .ctl_brnch(ctl_brnch), .ctl_mem_sc(ctl_mem_sc), .acc_nz(acc_nz),
    .mem_ready(mem_ready),
    .ir_we(ir_we), .pc_inc(pc_inc), .pc_load(pc_load), .acc_we(acc_we),
    .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .addr_sel(addr_sel),
    .busy(busy), .halted(halted), .err(err), .state(state),
    .instr_cnt(instr_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Phase-level model: what happens to one instruction at each boundary.
  always @(posedge clk) begin
    int nxt;
    bit starved;
    if (!rst_n) begin
      m_st = S_IDLE; m_cnt = '0; m_wait = 0; m_hp = 0; m_err = 0;
    end else begin
      starved = (m_st == S_FETCH || m_st == S_MEM) && !mem_ready;
      if (m_st != S_IDLE && halt_req) m_hp = 1;
      case (m_st)
        S_IDLE:   nxt = halt_req ? S_HALT : (start ? S_FETCH : S_IDLE);
        S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: nxt = ctl_mem_sc ? S_MEM : S_EXEC;
        S_EXEC:   nxt = S_WB;
        S_MEM:    nxt = mem_ready ? S_WB : S_MEM;
        S_WB: begin
          m_cnt = m_cnt + 16'd1;
          nxt = m_hp ? S_HALT : (step_mode ? S_PAUSE : S_FETCH);
        end
        S_PAUSE:  nxt = m_hp ? S_HALT : (start ? S_FETCH : S_PAUSE);
        default:  nxt = S_HALT;
      endcase
      if (starved) begin
        m_wait++;
        if (m_wait == 16) begin nxt = S_HALT; m_err = 1; end
      end
      if (!starved || nxt != m_st) m_wait = 0;
      m_st = nxt;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    bit on;
    if (cmp_en) begin
      on = rst_n;
      chk("state",    state,     m_st);
      chk("instr_cnt", instr_cnt, m_cnt);
      chk("err",      err,       m_err);
      chk("halted",   halted,    m_st == S_HALT);
      chk("busy",     busy,      on && m_st >= S_FETCH && m_st <= S_WB);
      chk("mem_re",   mem_re,    on && (m_st == S_FETCH || (m_st == S_MEM && !ctl_memWE)));
      chk("mem_we",   mem_we,    on && m_st == S_MEM && ctl_memWE);
      chk("addr_sel", addr_sel,  on && m_st == S_MEM);
      chk("ir_we",    ir_we,     on && m_st == S_FETCH && mem_ready);
      chk("pc_inc",   pc_inc,    on && m_st == S_FETCH && mem_ready);
      chk("acc_we",   acc_we,    on && m_st == S_WB && ctl_accWE);
      chk("reg_we",   reg_we,    on && m_st == S_WB && ctl_regWE);
      chk("pc_load",  pc_load,   on && m_st == S_WB && ctl_brnch && acc_nz);
      chk("pc_excl",  pc_inc & pc_load, 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_alu[5] = '{1, 2, 3, 5, 1};
    int exp_acc[5] = '{0, 0, 0, 1, 0};

    rst_n = 0; start = 0; step_mode = 0; halt_req = 0; opcode = 3'd0;
    ctl_regWE = 0; ctl_accWE = 0; ctl_memWE = 0; ctl_brnch = 0; ctl_mem_sc = 0;
    acc_nz = 0; mem_ready = 0;

    // Reset
    cyc(); cyc();
    cmp_en = 1;
    @(negedge clk);
    chk("rst_state", state, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", instr_cnt, 16'd0);

    // ALU path
    cyc(); rst_n = 1; start = 1; mem_ready = 1; ctl_accWE = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 0) start = 0;
      @(negedge clk);
      chk("alu_state", state, exp_alu[i]);
      chk("alu_accwe", acc_we, exp_acc[i]);
    end
    chk("alu_cnt", instr_cnt, 16'd1);

    // Store with three wait cycles
    cyc(); ctl_mem_sc = 1; ctl_memWE = 1; ctl_accWE = 0; mem_ready = 0;
    @(negedge clk); chk("st_decode", state, 3'd2);
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) mem_ready = 1;
      @(negedge clk);
      chk("st_mem", state, 3'd4);
      chk("st_memwe", mem_we, 1'b1);
      chk("st_memre", mem_re, 1'b0);
    end
    cyc(); @(negedge clk);
    chk("st_wb", state, 3'd5);
    chk("st_wb_memwe", mem_we, 1'b0);

    // Branch taken, then not taken
    cyc(); ctl_mem_sc = 0; ctl_memWE = 0; ctl_brnch = 1; acc_nz = 1;
    repeat (3) cyc();
    @(negedge clk);
    chk("br_wb", state, 3'd5);
    chk("br_pcload", pc_load, 1'b1);
    chk("br_pcinc", pc_inc, 1'b0);
    cyc(); acc_nz = 0;
    @(negedge clk);
    chk("br_fetch_pcinc", pc_inc, 1'b1);
    repeat (3) cyc();
    @(negedge clk);
    chk("brn_wb", state, 3'd5);
    chk("brn_pcload", pc_load, 1'b0);
    chk("brn_cnt", instr_cnt, 16'd3);

    // Step mode, then halt request during DECODE
    cyc(); step_mode = 1; ctl_brnch = 0;
    repeat (3) cyc();
    cyc(); @(negedge clk);
    chk("step_pause", state, 3'd6);
    chk("step_busy", busy, 1'b0);
    cyc(); @(negedge clk);
    chk("step_hold", state, 3'd6);
    start = 1;
    cyc(); start = 0; step_mode = 0;
    @(negedge clk); chk("step_resume", state, 3'd1);
    cyc(); halt_req = 1;
    cyc(); halt_req = 0;
    @(negedge clk); chk("hr_exec", state, 3'd3);
    cyc(); @(negedge clk); chk("hr_wb", state, 3'd5);
    cyc(); @(negedge clk);
    chk("hr_halt", state, 3'd7);
    chk("hr_halted", halted, 1'b1);
    chk("hr_cnt", instr_cnt, 16'd6);
    start = 1;
    repeat (2) cyc();
    start = 0;
    @(negedge clk); chk("hr_absorb", state, 3'd7);

    // Reset out of HALT clears the counter
    rst_n = 0;
    @(negedge clk); chk("rh_busy", busy, 1'b0);
    cyc(); rst_n = 1;
    @(negedge clk);
    chk("rh_state", state, 3'd0);
    chk("rh_cnt", instr_cnt, 16'd0);
    chk("rh_halted", halted, 1'b0);

    // Fetch timeout
    start = 1; mem_ready = 0;
    cyc(); start = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("to_fetch", state, 3'd1);
      cyc();
    end
    @(negedge clk);
    chk("to_halt", state, 3'd7);
    chk("to_err", err, 1'b1);
    chk("to_cnt", instr_cnt, 16'd0);
    cyc(); rst_n = 0;
    cyc(); rst_n = 1;
    @(negedge clk);
    chk("to_rst_state", state, 3'd0);
    chk("to_rst_err", err, 1'b0);

    // Reset in the middle of a MEM access
    start = 1; mem_ready = 1; ctl_mem_sc = 1; ctl_memWE = 1;
    cyc(); start = 0;
    cyc(); mem_ready = 0;
    cyc(); @(negedge clk); chk("mr_mem", state, 3'd4);
    cyc(); rst_n = 0;
    @(negedge clk);
    chk("mr_memwe", mem_we, 1'b0);
    chk("mr_busy", busy, 1'b0);
    cyc(); rst_n = 1;
    @(negedge clk); chk("mr_state", state, 3'd0);

    // halt_req in IDLE wins over start
    ctl_mem_sc = 0; ctl_memWE = 0; mem_ready = 1; start = 1; halt_req = 1;
    cyc(); start = 0; halt_req = 0;
    @(negedge clk);
    chk("ih_state", state, 3'd7);
    chk("ih_err", err, 1'b0);
    rst_n = 0;
    cyc(); rst_n = 1;

    // Counter wrap from 0xFFFF
    cyc();
    force dut.instr_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    cyc();
    release dut.instr_cnt_q;
    start = 1;
    cyc(); start = 0;
    repeat (2) cyc();
    cyc(); @(negedge clk);
    chk("wrap_wb", state, 3'd5);
    chk("wrap_pre", instr_cnt, 16'hFFFF);
    cyc(); @(negedge clk);
    chk("wrap_cnt", instr_cnt, 16'h0000);

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
